spi_host: RTL and testbench
===========================

SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 Parameter: CLK_DIV, default 4, SCK half-period in clk cycles (legal 1..255; 0 is illegal and is rejected at elaboration).
REQ-002 Port: clk  input  1  single clock for all logic.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: tx_valid_i  input  1  byte offered to send.
REQ-005 Port: tx_data_i  input  8  byte to send, MSB first.
REQ-006 Port: tx_last_i  input  1  offered byte ends the CS frame (used only with SPI_HOST_CS_HOLD_EN).
REQ-007 Port: tx_ready_o  output  1  host accepts a byte this cycle.
REQ-008 Port: rx_valid_o  output  1  one-cycle pulse: rx_data_o updated.
REQ-009 Port: rx_data_o  output  8  byte shifted in from spi_cipo_i.
REQ-010 Port: busy_o  output  1  high whenever state is not IDLE.
REQ-011 Port: spi_sck_o  output  1  SPI clock, mode 0 (idle low).
REQ-012 Port: spi_copi_o  output  1  controller-out data to the Xosera SPI target.
REQ-013 Port: spi_cipo_i  input  1  target-out data, already synchronous to clk.
REQ-014 Port: spi_cs_o  output  1  target select, active low.

Function
REQ-015 All outputs shall be registered.
REQ-016 States shall be IDLE, SETUP, SHIFT, TAIL, GAP and WAIT.
REQ-017 A handshake shall occur on a clk edge with tx_valid_i=1 and tx_ready_o=1.
- tx_ready_o=1 only in IDLE, and in WAIT when configured.
- tx_data_i and tx_last_i are captured at the handshake edge.
REQ-018 IDLE -> SETUP on handshake: spi_cs_o=0 and spi_copi_o=data[7] after that edge (edge 0).
REQ-019 SETUP shall last CLK_DIV cycles, then go to SHIFT.
REQ-020 SHIFT shall run 16 half-periods of CLK_DIV cycles each.
- Odd half-period ends: spi_sck_o rises and spi_cipo_i is sampled on that same edge.
- Even half-period ends: spi_sck_o falls and spi_copi_o presents the next bit.
REQ-021 Relative to edge 0, timing shall be:
- first SCK rise after edge CLK_DIV;
- eighth SCK fall after edge 16*CLK_DIV;
- rx_valid_o=1 for exactly the cycle after edge 16*CLK_DIV, with rx_data_o valid at the same time.
REQ-022 rx_data_o shall hold its value until the next rx_valid_o pulse.
REQ-023 SHIFT -> TAIL (spi_cs_o stays 0) for CLK_DIV cycles, then GAP.
- spi_cs_o=1 after edge 17*CLK_DIV.
REQ-024 GAP shall hold spi_cs_o=1 for CLK_DIV cycles, then go to IDLE.
- tx_ready_o=1 after edge 18*CLK_DIV.
REQ-025 spi_copi_o shall be 0 whenever spi_cs_o=1.
REQ-026 spi_sck_o shall be 0 in every state other than SHIFT.
REQ-027 tx_valid_i while tx_ready_o=0 shall have no effect; the byte stays pending on the interface.

Reset
REQ-028 While reset=1, the block shall be in IDLE and the outputs shall be:
- spi_cs_o=1, spi_sck_o=0, spi_copi_o=0;
- rx_valid_o=0, rx_data_o=0x00;
- busy_o=0, tx_ready_o=0.
REQ-029 tx_ready_o shall rise on the first clk edge after reset deasserts.
REQ-030 Reset asserted mid-byte shall abort immediately.
- No rx_valid_o pulse is produced for the aborted byte.
- The partial received byte is discarded.

Configuration
REQ-031 Macro SPI_HOST_CS_HOLD_EN defined:
- a byte accepted with tx_last_i=0 goes SHIFT -> WAIT instead of TAIL;
- WAIT holds spi_cs_o=0 and spi_sck_o=0, with tx_ready_o=1;
- a WAIT handshake goes directly to SHIFT, with spi_copi_o=data[7] after the accept edge (no SETUP phase);
- a byte accepted with tx_last_i=1 ends via TAIL and GAP.
REQ-032 Macro SPI_HOST_CS_HOLD_EN undefined:
- tx_last_i is ignored;
- WAIT is unreachable;
- every byte ends via TAIL and GAP.

Verification
REQ-033 CLK_DIV=4, send 0xA5 with cipo looping copi:
- spi_cs_o falls at edge 0, first SCK rise at edge 4;
- copi shows 1,0,1,0,0,1,0,1;
- rx_valid_o pulses in the cycle after edge 64 with rx_data_o=0xA5;
- spi_cs_o rises at edge 68, tx_ready_o rises at edge 72.
REQ-034 cipo held at 1, send 0x00:
- rx_data_o=0xFF, spi_copi_o is 0 for all 8 bits;
- exactly 8 SCK rising edges.
REQ-035 CLK_DIV=1, back-to-back valid sending 0x3C then 0xC3:
- two separate CS-low frames with a CS-high gap of at least 1 cycle;
- received bytes are correct.
REQ-036 Reset asserted at edge 30 of a byte:
- outputs go to reset values at once;
- no rx_valid_o pulse;
- the next byte after reset completes normally.
REQ-037 SPI_HOST_CS_HOLD_EN, send 0x12 (last=0) then 0x34 (last=1):
- spi_cs_o stays 0 across both bytes;
- 16 SCK rising edges;
- rx_valid_o pulses twice;
- CS rises CLK_DIV cycles after the second byte's final SCK fall.

Source files
------------

// File: rtl/spi_host.sv
// SPI mode-0 host: one byte per CS frame, MSB first, SCK half-period = CLK_DIV clk cycles.
// Optional macro SPI_HOST_CS_HOLD_EN keeps CS low between bytes until a byte marked last.
module spi_host #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_last_i,
   output logic       tx_ready_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       busy_o,
   output logic       spi_sck_o,
   output logic       spi_copi_o,
   input  logic       spi_cipo_i,
   output logic       spi_cs_o
);

   if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
      $error("spi_host: CLK_DIV must be 1..255");
   end

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, GAP, WAIT} state_t;

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] hp, hp_n;          // half-period ends already completed in this byte
   logic [6:0] tx_sh, tx_sh_n;    // bits still to present on copi
   logic [7:0] rx_sh, rx_sh_n;
   logic       sck_n, copi_n, cs_n, rx_valid_n;
   logic [7:0] rx_data_n;
   logic       hs;

`ifdef SPI_HOST_CS_HOLD_EN
   logic       last_q, last_n;
`else
   logic       unused_last;
   assign unused_last = tx_last_i;
`endif

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      hp_n       = hp;
      tx_sh_n    = tx_sh;
      rx_sh_n    = rx_sh;
      sck_n      = spi_sck_o;
      copi_n     = spi_copi_o;
      cs_n       = spi_cs_o;
      rx_valid_n = 1'b0;
      rx_data_n  = rx_data_o;
      hs         = tx_valid_i & tx_ready_o;
`ifdef SPI_HOST_CS_HOLD_EN
      last_n     = last_q;
`endif
      case (state)
         IDLE: if (hs) begin
            state_n = SETUP;
            cnt_n   = DIV_M1;
            tx_sh_n = tx_data_i[6:0];
            cs_n    = 1'b0;
            copi_n  = tx_data_i[7];
`ifdef SPI_HOST_CS_HOLD_EN
            last_n  = tx_last_i;
`endif
         end
         // The end of SETUP is the first half-period end: SCK rises and cipo is sampled.
         SETUP: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
         else begin
            state_n = SHIFT;
            cnt_n   = DIV_M1;
            hp_n    = 4'd1;
            sck_n   = 1'b1;
            rx_sh_n = {rx_sh[6:0], spi_cipo_i};
         end
         SHIFT: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
         else begin
            cnt_n = DIV_M1;
            hp_n  = hp + 4'd1;
            if (!hp[0]) begin
               sck_n   = 1'b1;
               rx_sh_n = {rx_sh[6:0], spi_cipo_i};
            end else begin
               sck_n   = 1'b0;
               copi_n  = tx_sh[6];
               tx_sh_n = {tx_sh[5:0], 1'b0};
               if (hp == 4'd15) begin
                  copi_n     = 1'b0;
                  rx_valid_n = 1'b1;
                  rx_data_n  = rx_sh;
`ifdef SPI_HOST_CS_HOLD_EN
                  state_n    = last_q ? TAIL : WAIT;
`else
                  state_n    = TAIL;
`endif
               end
            end
         end
         TAIL: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
         else begin
            state_n = GAP;
            cnt_n   = DIV_M1;
            cs_n    = 1'b1;
            copi_n  = 1'b0;
         end
         GAP: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
         else state_n = IDLE;
`ifdef SPI_HOST_CS_HOLD_EN
         // Next byte enters SHIFT with its first half-period still in progress.
         WAIT: if (hs) begin
            state_n = SHIFT;
            cnt_n   = DIV_M1;
            hp_n    = 4'd0;
            tx_sh_n = tx_data_i[6:0];
            copi_n  = tx_data_i[7];
            last_n  = tx_last_i;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         hp         <= 4'd0;
         tx_sh      <= 7'd0;
         rx_sh      <= 8'd0;
         spi_sck_o  <= 1'b0;
         spi_copi_o <= 1'b0;
         spi_cs_o   <= 1'b1;
         rx_valid_o <= 1'b0;
         rx_data_o  <= 8'd0;
         tx_ready_o <= 1'b0;
         busy_o     <= 1'b0;
`ifdef SPI_HOST_CS_HOLD_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         hp         <= hp_n;
         tx_sh      <= tx_sh_n;
         rx_sh      <= rx_sh_n;
         spi_sck_o  <= sck_n;
         spi_copi_o <= copi_n;
         spi_cs_o   <= cs_n;
         rx_valid_o <= rx_valid_n;
         rx_data_o  <= rx_data_n;
         tx_ready_o <= (state_n == IDLE) || (state_n == WAIT);
         busy_o     <= (state_n != IDLE);
`ifdef SPI_HOST_CS_HOLD_EN
         last_q     <= last_n;
`endif
      end
   end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: CLK_DIV=4 and CLK_DIV=1 instances, outputs checked every cycle
// against a timing model expressed as edge counts relative to the accept edge.
module tb_spi_host;

   logic       clk = 1'b0;
   logic       reset, sel, tx_valid, tx_last, loop;
   logic [7:0] tx_data, cipo_drv;
   int         nvec = 0, nerr = 0;

   logic       rdy4, rxv4, busy4, sck4, copi4, cs4;
   logic       rdy1, rxv1, busy1, sck1, copi1, cs1;
   logic [7:0] rxd4, rxd1;
   logic       cs, sck, copi, rxv, ready, busy, cipo, vld4, vld1;
   logic [7:0] rxd, bus;

   always #5 clk = ~clk;

   assign vld4  = tx_valid & ~sel;
   assign vld1  = tx_valid & sel;
   assign cs    = sel ? cs1   : cs4;
   assign sck   = sel ? sck1  : sck4;
   assign copi  = sel ? copi1 : copi4;
   assign rxv   = sel ? rxv1  : rxv4;
   assign ready = sel ? rdy1  : rdy4;
   assign busy  = sel ? busy1 : busy4;
   assign rxd   = sel ? rxd1  : rxd4;
   assign cipo  = loop ? copi : cipo_drv;
   assign bus   = {2'b00, cs, sck, copi, rxv, ready, busy};

   spi_host #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .reset(reset), .tx_valid_i(vld4), .tx_data_i(tx_data), .tx_last_i(tx_last),
      .tx_ready_o(rdy4), .rx_valid_o(rxv4), .rx_data_o(rxd4), .busy_o(busy4),
      .spi_sck_o(sck4), .spi_copi_o(copi4), .spi_cipo_i(cipo), .spi_cs_o(cs4));

   spi_host #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .tx_valid_i(vld1), .tx_data_i(tx_data), .tx_last_i(tx_last),
      .tx_ready_o(rdy1), .rx_valid_o(rxv1), .rx_data_o(rxd1), .busy_o(busy1),
      .spi_sck_o(sck1), .spi_copi_o(copi1), .spi_cipo_i(cipo), .spi_cs_o(cs1));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Expected {cs,sck,copi,rx_valid,ready,busy} after edge k of a byte (edge 0 = accept).
   function automatic logic [7:0] model(int k, int dv, logic [7:0] d, bit cont);
      logic c_s, s_k, c_o, r_v, r_y, b_y;
      c_s = (k >= 17*dv);
      s_k = (k < 16*dv) && ((k/dv) % 2 == 1);
      c_o = (k < 16*dv) ? d[7 - k/(2*dv)] : 1'b0;
      r_v = (k == 16*dv);
      r_y = (k >= 18*dv);
      b_y = (k < 18*dv);
      if (cont && k == 16*dv) begin
         c_s = 1'b0;
         r_y = 1'b1;
      end
      return {2'b00, c_s, s_k, c_o, r_v, r_y, b_y};
   endfunction

   task automatic run_byte(input logic [7:0] d, input bit lp, input logic [7:0] c,
                           input bit hold, input int abort_k, input bit last);
      int dv, kend, n;
      bit cont;
      logic [7:0] xrx;
      dv   = sel ? 1 : 4;
      cont = 1'b0;
`ifdef SPI_HOST_CS_HOLD_EN
      cont = !last;
`endif
      kend = cont ? 16*dv : 18*dv;
      xrx  = lp ? d : c;
      n = 0;
      while (ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n == 64) chk("ready_wait", {7'b0, ready}, 8'h01);
      loop     = lp;
      tx_valid = 1'b1;
      tx_data  = d;
      tx_last  = last;
      cipo_drv = c[7];
      for (int k = 0; k <= kend; k++) begin
         @(negedge clk);
         chk($sformatf("bus k=%0d d=%h div=%0d", k, d, dv), bus, model(k, dv, d, cont));
         if (k == 16*dv || k == kend) chk($sformatf("rx_data k=%0d", k), rxd, xrx);
         if (k == abort_k) begin
            reset = 1'b1;
            tx_valid = 1'b0;
            #1;
            chk("abort_bus", bus, 8'h20);
            chk("abort_rx", rxd, 8'h00);
            repeat (3) begin
               @(negedge clk);
               chk("abort_hold", bus, 8'h20);
            end
            reset = 1'b0;
            @(negedge clk);
            chk("abort_ready", bus, 8'h22);
            return;
         end
         tx_valid = hold && (k < kend);
         if (hold) tx_data = 8'($urandom);
         if (k < 16*dv) cipo_drv = c[7 - k/(2*dv)];
      end
      tx_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; tx_valid = 1'b0; tx_last = 1'b1; loop = 1'b1;
      tx_data = 8'h00; cipo_drv = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_bus", bus, 8'h20);
      chk("reset_rx", rxd, 8'h00);
      reset = 1'b0;
      #1 chk("deassert_bus", bus, 8'h20);
      @(negedge clk);
      chk("ready_after_reset", bus, 8'h22);

      run_byte(8'hA5, 1'b1, 8'h00, 1'b0, -1, 1'b1);
      run_byte(8'h00, 1'b0, 8'hFF, 1'b0, -1, 1'b1);
      for (int i = 0; i < 6; i++)
         run_byte(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), -1,
                  (i == 5) ? 1'b1 : 1'($urandom));

      @(negedge clk);
      sel = 1'b1;
      run_byte(8'h3C, 1'b1, 8'h00, 1'b1, -1, 1'b1);
      run_byte(8'hC3, 1'b1, 8'h00, 1'b1, -1, 1'b1);
      for (int i = 0; i < 4; i++)
         run_byte(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), -1, 1'b1);

      @(negedge clk);
      sel = 1'b0;
      run_byte(8'($urandom), 1'b1, 8'h00, 1'b0, 30, 1'b1);
      run_byte(8'h5A, 1'b0, 8'($urandom), 1'b0, -1, 1'b1);

`ifdef SPI_HOST_CS_HOLD_EN
      run_byte(8'h12, 1'b1, 8'h00, 1'b0, -1, 1'b0);
      run_byte(8'h34, 1'b1, 8'h00, 1'b0, -1, 1'b1);
`endif

      repeat (2) @(negedge clk);
      chk("final_idle", bus, 8'h22);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
